// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 serial receiver
// with a first-word-fall-through output FIFO.
module uart_rx #(
  parameter int CLKS_PER_BIT        = 139,
  parameter int WORDBITS            = 8,
  parameter int OUTPUT_BUFFER_DEPTH = 32
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                rxIn,
  input  logic                rxRead,
  output logic [WORDBITS-1:0] rxOut,
  output logic                rxValid,
  output logic [$clog2(OUTPUT_BUFFER_DEPTH):0] rxCount,
  output logic                frameError,
  output logic                overflow
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = (WORDBITS > 1) ? $clog2(WORDBITS) : 1;
  localparam int PW = $clog2(OUTPUT_BUFFER_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BW-1:0] B_LAST = BW'(WORDBITS - 1);
  localparam logic [CW-1:0] C_FULL = CW'(OUTPUT_BUFFER_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    STARTBIT,
    DATA,
    STOPBIT,
    BREAKWAIT
  } state_t;

  state_t              state;
  logic [TW-1:0]       timer;
  logic [BW-1:0]       bit_idx;
  logic [WORDBITS-1:0] shift;
  logic                sync1;
  logic                rxS;

  logic [WORDBITS-1:0] buffer [OUTPUT_BUFFER_DEPTH];
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [CW-1:0]       count;

  logic stop_tick;
  logic push_req;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign stop_tick = (state == STOPBIT) && (timer == T_LAST);
  assign push_req  = stop_tick && rxS;
  assign full      = (count == C_FULL);
  assign pop       = rxRead && rxValid;
  // A pop on the same edge frees a slot for the incoming word.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  assign rxValid = (count != '0);
  assign rxCount = count;
  assign rxOut   = buffer[rd_ptr];

  // Two-flop synchronizer; idles high so reset never looks like a start.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      sync1 <= 1'b1;
      rxS   <= 1'b1;
    end else begin
      sync1 <= rxIn;
      rxS   <= sync1;
    end
  end

  // Frame FSM: centre-sample start, data and stop bits.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      frameError <= 1'b0;
    end else begin
      frameError <= 1'b0;
      unique case (state)
        IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
          if (!rxS) state <= STARTBIT;
        end
        STARTBIT: begin
          if (timer == T_HALF) begin
            timer <= '0;
            state <= rxS ? IDLE : DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == T_LAST) begin
            timer          <= '0;
            shift[bit_idx] <= rxS;
            if (bit_idx == B_LAST) begin
              bit_idx <= '0;
              state   <= STOPBIT;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOPBIT: begin
          if (timer == T_LAST) begin
            timer <= '0;
            if (rxS) begin
              state <= IDLE;
            end else begin
              frameError <= 1'b1;
              state      <= BREAKWAIT;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        BREAKWAIT: begin
          timer <= '0;
          if (rxS) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and overflow pulse.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge clock) begin
    if (push) buffer[wr_ptr] <= shift;
  end

endmodule
